// File: rtl/key_event_queue.sv
// PS/2 set-2 scan-code decoder producing make/break/auto-repeat key events,
// with a held-key mask and a first-word-fall-through event FIFO.
module key_event_queue #(
    parameter int CODE_W       = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  scan_data,
    input  logic                        scan_valid,
    output logic [CODE_W-1:0]           evt_code,
    output logic                        evt_break,
    output logic                        evt_repeat,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [9:0]                  held_mask,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    input  logic                        clr_overflow
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RC_W    = $clog2(CNT_MAX + 1);
    localparam int ENTRY_W = CODE_W + 2;
    localparam logic [PTR_W:0] FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [RC_W-1:0] RC_DELAY = RC_W'(REPEAT_DELAY);
    localparam logic [RC_W-1:0] RC_RATE  = RC_W'(REPEAT_RATE);
    localparam logic [RC_W-1:0] RC_ONE   = RC_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

    function automatic logic [3:0] map_scan(input logic [7:0] b);
        case (b)
            8'h1C:   map_scan = 4'd1;
            8'h1B:   map_scan = 4'd2;
            8'h1D:   map_scan = 4'd3;
            8'h23:   map_scan = 4'd4;
            8'h16:   map_scan = 4'd5;
            8'h1E:   map_scan = 4'd6;
            8'h26:   map_scan = 4'd7;
            8'h25:   map_scan = 4'd8;
            8'h76:   map_scan = 4'd9;
            default: map_scan = 4'd0;
        endcase
    endfunction

    // Input byte is registered, so events push one edge after the byte is sampled.
    logic [7:0] byte_q;
    logic       byte_v_q;
    state_t     state_q, state_nxt;
    logic [9:0] held_q, held_nxt;
    logic       rpt_active_q, rpt_active_nxt;
    logic [3:0] rpt_key_q, rpt_key_nxt;
    logic [RC_W-1:0] rpt_cnt_q, rpt_cnt_nxt;
    logic [3:0] scan_code;
    logic       is_make, is_break, make_new, scan_push, rpt_push;
    logic [ENTRY_W-1:0] push_entry;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic               overflow_q;
    logic               push, pop, wr_en, drop;
    logic [ENTRY_W-1:0] head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_q   <= 8'h00;
            byte_v_q <= 1'b0;
        end else begin
            byte_q   <= scan_data;
            byte_v_q <= scan_valid;
        end
    end

    assign scan_code = map_scan(byte_q);

    always_comb begin
        state_nxt = state_q;
        is_make   = 1'b0;
        is_break  = 1'b0;
        if (byte_v_q) begin
            case (state_q)
                S_IDLE: begin
                    if (byte_q == 8'hF0)      state_nxt = S_BRK;
                    else if (byte_q == 8'hE0) state_nxt = S_EXT;
                    else                      is_make = (scan_code != 4'd0);
                end
                S_BRK: begin
                    state_nxt = S_IDLE;
                    is_break  = (scan_code != 4'd0);
                end
                S_EXT:   state_nxt = (byte_q == 8'hF0) ? S_EXT_BRK : S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // A make for an already-held key is keyboard typematic and is ignored.
    assign make_new  = is_make && !held_q[scan_code];
    assign scan_push = make_new || is_break;
    assign rpt_push  = rpt_active_q && (rpt_cnt_q == RC_ONE) && !scan_push;

    always_comb begin
        held_nxt       = held_q;
        rpt_active_nxt = rpt_active_q;
        rpt_key_nxt    = rpt_key_q;
        rpt_cnt_nxt    = rpt_cnt_q;
        if (rpt_active_q) begin
            if (rpt_cnt_q != RC_ONE)  rpt_cnt_nxt = rpt_cnt_q - RC_ONE;
            else if (!scan_push)      rpt_cnt_nxt = RC_RATE;
        end
        if (make_new) begin
            held_nxt[scan_code] = 1'b1;
            rpt_active_nxt      = 1'b1;
            rpt_key_nxt         = scan_code;
            rpt_cnt_nxt         = RC_DELAY;
        end else if (is_break) begin
            held_nxt[scan_code] = 1'b0;
            if (rpt_active_q && (rpt_key_q == scan_code)) rpt_active_nxt = 1'b0;
        end
    end

    always_comb begin
        push_entry = {CODE_W'(rpt_key_q), 1'b0, 1'b1};
        if (scan_push) push_entry = {CODE_W'(scan_code), is_break, 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            held_q       <= 10'h000;
            rpt_active_q <= 1'b0;
            rpt_key_q    <= 4'd0;
            rpt_cnt_q    <= '0;
        end else begin
            state_q      <= state_nxt;
            held_q       <= held_nxt;
            rpt_active_q <= rpt_active_nxt;
            rpt_key_q    <= rpt_key_nxt;
            rpt_cnt_q    <= rpt_cnt_nxt;
        end
    end

    // Full FIFO still accepts a push when the head is popped in the same cycle.
    assign push  = scan_push || rpt_push;
    assign pop   = (count_q != '0) && evt_ready;
    assign wr_en = push && ((count_q != FULL_CNT) || pop);
    assign drop  = push && (count_q == FULL_CNT) && !pop;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_en && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !wr_en) count_q <= count_q - 1'b1;
            if (drop)              overflow_q <= 1'b1;
            else if (clr_overflow) overflow_q <= 1'b0;
        end
    end

    assign head       = mem[rd_ptr_q];
    assign evt_valid  = (count_q != '0);
    assign evt_code   = evt_valid ? head[ENTRY_W-1:2] : '0;
    assign evt_break  = evt_valid && head[1];
    assign evt_repeat = evt_valid && head[0];
    assign held_mask  = held_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Turns the PS/2 set-2 scan-code byte stream into key events using the team's key-code encoding.
- Events are make, break and auto-repeat.
- Tracks which mapped keys are currently held.
- Buffers events in a parametrised FIFO for the menu/game logic; successor to the fixed 4-bit key-code constants, generalised in code width, queue depth and repeat behaviour.

Parameters:
CODE_W, 4, key-code width; must be >= 4; codes zero-extended
FIFO_DEPTH, 8, event queue entries; power of 2, >= 2
REPEAT_DELAY, 25_000_000, clk cycles from make to first repeat; >= 1
REPEAT_RATE, 5_000_000, clk cycles between subsequent repeats; >= 1

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
scan_data  in  8  received scan-code byte
scan_valid  in  1  one-cycle strobe, scan_data valid
evt_code  out  CODE_W  key code of head event
evt_break  out  1  head event is a release
evt_repeat  out  1  head event is an auto-repeat make
evt_valid  out  1  FIFO not empty
evt_ready  in  1  consumer accepts head event
held_mask  out  10  bit k = key with code k held; bit 0 always 0
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries stored
overflow  out  1  sticky: an event was dropped
clr_overflow  in  1  clears overflow

Behaviour:
- Reset (rst_n low at clk edge): FSM IDLE, FIFO empty, held_mask=0, repeat inactive, overflow=0, all outputs 0.
- Key map (scan -> code): 1C->1 A, 1B->2 S, 1D->3 W, 23->4 D, 16->5 '1', 1E->6 '2', 26->7 '3', 25->8 '4', 76->9 Esc. All other bytes are unmapped. Code 0 (released) is never queued.
- Prefix FSM, advancing only on scan_valid:
  - IDLE: F0->BRK; E0->EXT; mapped->make; else stay.
  - BRK: mapped->break; any byte->IDLE.
  - EXT: F0->EXT_BRK; any other byte discarded->IDLE.
  - EXT_BRK: any byte discarded->IDLE.
  - Extended keys never generate events.
- Make for code k:
  - held_mask[k]=0: set it; push {k, break=0, repeat=0}; k becomes repeat key; repeat counter loads REPEAT_DELAY.
  - held_mask[k]=1 (keyboard typematic): ignored, no push, counter untouched.
- Break for code k:
  - Clear held_mask[k]; push {k, break=1, repeat=0}, even if k was not held.
  - If k is the repeat key, repeat becomes inactive.
- Auto-repeat: while active, the counter decrements each cycle. On reaching 1 it pushes {key, 0, repeat=1} and reloads REPEAT_RATE.
- Push collision: if a scan-derived push and a repeat push fall in the same cycle, the scan push wins. The repeat counter holds at 1 and the repeat pushes next cycle, unless the scan event deactivated the repeat.
- FIFO behaviour:
  - First-word-fall-through. evt_* reflect the head entry; evt_valid = count != 0.
  - Pop when evt_valid && evt_ready.
  - Latency: the scan byte completing an event at edge N gives evt_valid=1 after edge N+1 when the FIFO was empty.
- FIFO full:
  - A push while full and not popping in the same cycle is dropped; overflow=1. held_mask and repeat state still update.
  - Push and pop in the same cycle while full: both succeed, count unchanged.
  - Pop while empty: no effect.
- overflow: clr_overflow clears it. If clr_overflow and a new drop coincide, overflow ends at 1.
- Pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.

Test Plan:
- Make/break W, evt_ready=1:
  - scan 1D -> one event {code=3, break=0, repeat=0}, held_mask=0x008.
  - then F0,1D -> {3,1,0}, held_mask=0.
- Extended and unmapped bytes:
  - E0,75 then E0,F0,75 then 5A -> no events.
  - then 1C -> {1,0,0}.
- Repeat with REPEAT_DELAY=20, REPEAT_RATE=5:
  - make 76, hold -> repeat events {9,0,1} at 20, 25, 30 cycles after the make push.
  - F0,76 -> break; no further repeats.
- Typematic suppression: scan 1B three times -> exactly one make {2,0,0}; held_mask[2]=1.
- Overflow, FIFO_DEPTH=8, evt_ready=0:
  - nine distinct makes/breaks -> fifo_count=8, overflow=1, ninth event lost, held_mask still updated.
  - Drain -> events in order; clr_overflow -> 0.
- Reset mid-prefix: F0, then rst_n low one cycle, then 1C -> make {1,0,0}, not a break.
